// File: rtl/instr_fetch.sv
// IF stage: owns the PC, addresses instr_mem and fills the IF/ID register.
// Optional performance counters are enabled with `define IFETCH_PERF_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
    typedef enum logic [2:0] {
        P_NONE, P_REDIRECT, P_MISALIGN, P_STALL, P_FLUSH, P_FETCH
    } path_t;

    state_t      r_state, w_state_nxt;
    path_t       w_path;
    logic [31:0] r_pc, w_pc_nxt, w_pc_plus4;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_ifpc, w_ifpc_nxt;
    logic [31:0] r_ifpc4, w_ifpc4_nxt;
    logic        r_valid, w_valid_nxt;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Edge action for this cycle; only RUN ever selects one.
    always_comb begin
        w_path = P_NONE;
        if (r_state == S_RUN) begin
            if (redirect_valid && (redirect_pc[1:0] == 2'b00)) w_path = P_REDIRECT;
            else if (redirect_valid)                           w_path = P_MISALIGN;
            else if (stall_f)                                  w_path = P_STALL;
            else if (flush_d)                                  w_path = P_FLUSH;
            else                                               w_path = P_FETCH;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first so no latch is inferred.
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_ifpc_nxt  = r_ifpc;
        w_ifpc4_nxt = r_ifpc4;
        w_valid_nxt = r_valid;
        if (r_state == S_BOOT) w_state_nxt = S_RUN;
        unique case (w_path)
            P_REDIRECT: begin
                w_pc_nxt    = redirect_pc;
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
            end
            P_MISALIGN: begin
                w_state_nxt = S_HALT;
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
            end
            P_STALL: begin
                if (flush_d) begin
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end
            end
            P_FLUSH: begin
                w_pc_nxt    = w_pc_plus4;
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
            end
            P_FETCH: begin
                w_pc_nxt    = w_pc_plus4;
                w_instr_nxt = imem_rdata;
                w_ifpc_nxt  = r_pc;
                w_ifpc4_nxt = w_pc_plus4;
                w_valid_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_ifpc  <= 32'd0;
            r_ifpc4 <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_ifpc  <= w_ifpc_nxt;
            r_ifpc4 <= w_ifpc4_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetched, r_perf_bubbles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= 32'd0;
            r_perf_bubbles <= 32'd0;
        end else begin
            if (w_path == P_FETCH) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_path inside {P_REDIRECT, P_MISALIGN, P_STALL, P_FLUSH})
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

    assign imem_addr      = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_ifpc;
    assign if_id_pc_plus4 = r_ifpc4;
    assign if_id_valid    = r_valid;
    assign halted         = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch, stall, redirect, flush, wrap, halt.
// Perf-counter scenario is compiled in when IFETCH_PERF_EN is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall_f = 1'b0, flush_d = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
    logic        if_id_valid, halted;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [129:0] obs, exp_v;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall_f        (stall_f),
        .flush_d        (flush_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // Memory image: word i holds 32'h1000_0000 + i.
    assign imem_rdata = 32'h1000_0000 + {2'b00, imem_addr[31:2]};
    // Observation vector: {imem_addr, instr, pc, pc_plus4, valid, halted}
    assign obs = {imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, halted};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic st, input logic fl);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall_f        = st;
        flush_d        = fl;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; exp_v = {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL reset_state: got %h exp %h", obs, exp_v); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; exp_v = {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL boot_bubble: got %h exp %h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_fetch();
        tick();
        n_total++; exp_v = {32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL fetch0: got %h exp %h", obs, exp_v); else n_pass++;
        tick();
        n_total++; exp_v = {32'h8, 32'h1000_0001, 32'h4, 32'h8, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL fetch1: got %h exp %h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_stall();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++; exp_v = {32'h8, 32'h1000_0001, 32'h4, 32'h8, 1'b1, 1'b0};
            if (obs !== exp_v) $display("FAIL stall_hold%0d: got %h exp %h", i, obs, exp_v); else n_pass++;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        n_total++; exp_v = {32'hC, 32'h1000_0002, 32'h8, 32'hC, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL stall_release: got %h exp %h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_redirect();
        repeat (2) tick();
        n_total++; exp_v = {32'h14, 32'h1000_0004, 32'h10, 32'h14, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL pre_redirect: got %h exp %h", obs, exp_v); else n_pass++;
        drive(1'b1, 32'h3C, 1'b0, 1'b0);
        tick();
        n_total++; exp_v = {32'h3C, 32'h13, 32'h10, 32'h14, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL redirect_bubble: got %h exp %h", obs, exp_v); else n_pass++;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        n_total++; exp_v = {32'h40, 32'h1000_000F, 32'h3C, 32'h40, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL redirect_target: got %h exp %h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_priority();
        drive(1'b1, 32'h8C, 1'b1, 1'b1);
        tick();
        n_total++; exp_v = {32'h8C, 32'h13, 32'h3C, 32'h40, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL redirect_over_stall_flush: got %h exp %h", obs, exp_v); else n_pass++;
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        n_total++; exp_v = {32'h14, 32'h13, 32'h3C, 32'h40, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL flush_alone: got %h exp %h", obs, exp_v); else n_pass++;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        n_total++; exp_v = {32'h18, 32'h1000_0005, 32'h14, 32'h18, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL after_flush: got %h exp %h", obs, exp_v); else n_pass++;
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        n_total++; exp_v = {32'h18, 32'h13, 32'h14, 32'h18, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL stall_plus_flush: got %h exp %h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        n_total++; exp_v = {32'hFFFF_FFFC, 32'h13, 32'h14, 32'h18, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL wrap_redirect: got %h exp %h", obs, exp_v); else n_pass++;
        // Misaligned target with redirect_valid low must be ignored.
        drive(1'b0, 32'h3E, 1'b0, 1'b0);
        tick();
        n_total++; exp_v = {32'h0, 32'h4FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL wrap_fetch: got %h exp %h", obs, exp_v); else n_pass++;
        tick();
        n_total++; exp_v = {32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL post_wrap_fetch: got %h exp %h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_halt();
        drive(1'b1, 32'h3E, 1'b0, 1'b0);
        tick();
        n_total++; exp_v = {32'h4, 32'h13, 32'h0, 32'h4, 1'b0, 1'b1};
        if (obs !== exp_v) $display("FAIL halt_entry: got %h exp %h", obs, exp_v); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 32'h80, i[1], i[2]);
            tick();
            n_total++; exp_v = {32'h4, 32'h13, 32'h0, 32'h4, 1'b0, 1'b1};
            if (obs !== exp_v) $display("FAIL halt_frozen%0d: got %h exp %h", i, obs, exp_v); else n_pass++;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_total++; exp_v = {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL async_reset: got %h exp %h", obs, exp_v); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_total++; exp_v = {32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL restart_fetch: got %h exp %h", obs, exp_v); else n_pass++;
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        #1;
        n_total++;
        if ({perf_fetched, perf_bubbles} !== 64'h0)
            $display("FAIL perf_reset: got %h/%h exp 0/0", perf_fetched, perf_bubbles);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        repeat (5) tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_total++;
        if ({perf_fetched, perf_bubbles} !== {32'd5, 32'd3})
            $display("FAIL perf_counts: got %0d/%0d exp 5/3", perf_fetched, perf_bubbles);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({perf_fetched, perf_bubbles} !== 64'h0)
            $display("FAIL perf_rst_clear: got %h/%h exp 0/0", perf_fetched, perf_bubbles);
        else n_pass++;
        tick();
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_priority();
        test_wrap();
        test_halt();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
